// File: rtl/rf_pkg.sv
// Shared defaults and types for the reg_file_sb register file and its read ports.
package rf_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          NUM_REGS_DEF  = 32;
    localparam logic [31:0] RESET_VAL_DEF = 32'h0000_0001;
    localparam int          ZERO_REG      = 0;

    typedef logic [$clog2(NUM_REGS_DEF)-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, two read ports and scoreboard set port.
interface reg_file_sb_if #(
    parameter int DATA_W   = rf_pkg::DATA_W_DEF,
    parameter int NUM_REGS = rf_pkg::NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);

    logic                Enable;
    logic                RegWrEn;
    logic [ADDR_W-1:0]   WrAddr;
    logic [DATA_W-1:0]   WriteData;
    logic [ADDR_W-1:0]   RdAddrA;
    logic [ADDR_W-1:0]   RdAddrB;
    logic [DATA_W-1:0]   RdDataA;
    logic [DATA_W-1:0]   RdDataB;
    logic                RdBusyA;
    logic                RdBusyB;
    logic                SbSetEn;
    logic [ADDR_W-1:0]   SbSetAddr;
    logic [NUM_REGS-1:0] BusyVec;

    modport master (
        output Enable, RegWrEn, WrAddr, WriteData, RdAddrA, RdAddrB, SbSetEn, SbSetAddr,
        input  RdDataA, RdDataB, RdBusyA, RdBusyB, BusyVec
    );

    modport slave (
        input  Enable, RegWrEn, WrAddr, WriteData, RdAddrA, RdAddrB, SbSetEn, SbSetAddr,
        output RdDataA, RdDataB, RdBusyA, RdBusyB, BusyVec
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register masking, busy lookup and, when
// REGFILE_BYPASS_EN is defined, same-cycle write-data forwarding.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  entries,
    input  logic [NUM_REGS-1:0]              busy_vec,
    input  logic                             wr_fire,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             sb_set_en,
    input  logic [ADDR_W-1:0]                sb_set_addr,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_busy
);

    logic              is_zero;
    logic [DATA_W-1:0] stored;

    assign is_zero = (rd_addr == ADDR_W'(ZERO_REG));
    assign stored  = is_zero ? '0 : entries[rd_addr];

`ifdef REGFILE_BYPASS_EN
    logic hit;

    // wr_fire already excludes entry 0, so a hit never forwards into the zero register
    assign hit     = wr_fire && (rd_addr == wr_addr);
    assign rd_data = hit ? wr_data : stored;
    assign rd_busy = hit ? (sb_set_en && (sb_set_addr == rd_addr)) : busy_vec[rd_addr];
`else
    logic unused_bypass;

    assign unused_bypass = ^{wr_fire, wr_addr, wr_data, sb_set_en, sb_set_addr};
    assign rd_data       = stored;
    assign rd_busy       = busy_vec[rd_addr];
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Register file with hardwired-zero entry 0, two read ports, one write port and a
// per-entry busy scoreboard. Optional same-cycle forwarding via REGFILE_BYPASS_EN.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                NUM_REGS  = NUM_REGS_DEF,
    parameter int                ADDR_W    = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
    input  logic          Clk,
    input  logic          Reset_,
    reg_file_sb_if.slave  bus
);

    logic [DATA_W-1:0]               mem [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]             busy_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] entries;
    logic [NUM_REGS-1:0]             busy_vec;
    logic                            wr_fire;

    assign wr_fire  = bus.Enable && bus.RegWrEn && (bus.WrAddr != ADDR_W'(ZERO_REG));
    assign busy_vec = {busy_q, 1'b0};
    assign bus.BusyVec = busy_vec;

    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_fire && (bus.WrAddr == ADDR_W'(i))) begin
                    mem[i] <= bus.WriteData;
                end
            end
        end
    end

    // A new producer issued in the same cycle the old one retires keeps the entry busy
    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            busy_q <= '0;
        end else if (bus.Enable) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (bus.SbSetEn && (bus.SbSetAddr == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (bus.RegWrEn && (bus.WrAddr == ADDR_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        entries[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            entries[i] = mem[i];
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .rd_addr     (bus.RdAddrA),
        .entries     (entries),
        .busy_vec    (busy_vec),
        .wr_fire     (wr_fire),
        .wr_addr     (bus.WrAddr),
        .wr_data     (bus.WriteData),
        .sb_set_en   (bus.SbSetEn),
        .sb_set_addr (bus.SbSetAddr),
        .rd_data     (bus.RdDataA),
        .rd_busy     (bus.RdBusyA)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .rd_addr     (bus.RdAddrB),
        .entries     (entries),
        .busy_vec    (busy_vec),
        .wr_fire     (wr_fire),
        .wr_addr     (bus.WrAddr),
        .wr_data     (bus.WriteData),
        .sb_set_en   (bus.SbSetEn),
        .sb_set_addr (bus.SbSetAddr),
        .rd_data     (bus.RdDataB),
        .rd_busy     (bus.RdBusyB)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default 32x32 instance plus an 8x16 instance.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_reg_file_sb;

    logic Clk;
    logic Reset_;

    reg_file_sb_if bus ();
    reg_file_sb_if #(.DATA_W(16), .NUM_REGS(8)) bus_s ();

    reg_file_sb u_dut (
        .Clk    (Clk),
        .Reset_ (Reset_),
        .bus    (bus)
    );

    reg_file_sb #(
        .DATA_W    (16),
        .NUM_REGS  (8),
        .RESET_VAL (16'h00FF)
    ) u_small (
        .Clk    (Clk),
        .Reset_ (Reset_),
        .bus    (bus_s)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 Clk = ~Clk;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0:       return bus.RdDataA;
            1:       return bus.RdDataB;
            2:       return {31'd0, bus.RdBusyA};
            3:       return {31'd0, bus.RdBusyB};
            4:       return bus.BusyVec;
            5:       return {16'd0, bus_s.RdDataA};
            6:       return {16'd0, bus_s.RdDataB};
            default: return {24'd0, bus_s.BusyVec};
        endcase
    endfunction

    // Monitor: drains the expectation queue each time the outputs are presented
    initial begin
        exp_t        it;
        logic [31:0] act;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                act = actual(it.sel);
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s actual %h required %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_q.push_back('{name, sel, exp});
    endtask

    task automatic present();
        ->chk_ev;
        #1;
    endtask

    task automatic idle();
        bus.Enable    = 1'b1;
        bus.RegWrEn   = 1'b0;
        bus.SbSetEn   = 1'b0;
        bus.WrAddr    = '0;
        bus.SbSetAddr = '0;
        bus.WriteData = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        Clk = 1'b0;
        Reset_ = 1'b1;
        idle();
        bus.RdAddrA = 5'd0;
        bus.RdAddrB = 5'd5;
        bus_s.Enable = 1'b0; bus_s.RegWrEn = 1'b0; bus_s.SbSetEn = 1'b0;
        bus_s.WrAddr = '0; bus_s.SbSetAddr = '0; bus_s.WriteData = '0;
        bus_s.RdAddrA = 3'd1;
        bus_s.RdAddrB = 3'd7;

        // Asynchronous reset between edges
        #2 Reset_ = 1'b0;
        #1;
        expect_val("rst_rd0", 0, 32'h0);
        expect_val("rst_rd5", 1, 32'h1);
        expect_val("rst_busyvec", 4, 32'h0);
        expect_val("rst_busyA", 2, 32'h0);
        expect_val("rst_small_rd1", 5, 32'h00FF);
        expect_val("rst_small_rd7", 6, 32'h00FF);
        expect_val("rst_small_busyvec", 7, 32'h0);
        present();
        bus.RdAddrA = 5'd31;
        #1;
        expect_val("rst_rd31", 0, 32'h1);
        present();

        // Write DEADBEEF to entry 7
        @(negedge Clk);
        Reset_ = 1'b1;
        bus.RegWrEn = 1'b1; bus.WrAddr = 5'd7; bus.WriteData = 32'hDEAD_BEEF;
        bus.RdAddrA = 5'd7;
        @(negedge Clk);
        idle();
        #1;
        expect_val("wr7_rd", 0, 32'hDEAD_BEEF);
        present();

        // Write to entry 0 is discarded
        bus.RegWrEn = 1'b1; bus.WrAddr = 5'd0; bus.WriteData = 32'h1234;
        bus.RdAddrA = 5'd0; bus.RdAddrB = 5'd0;
        #1;
        expect_val("wr0_same_cycle", 0, 32'h0);
        present();
        @(negedge Clk);
        idle();
        #1;
        expect_val("wr0_next_cycle", 1, 32'h0);
        present();

        // Enable low blocks the write
        bus.Enable = 1'b0; bus.RegWrEn = 1'b1; bus.WrAddr = 5'd3; bus.WriteData = 32'hFFFF;
        bus.RdAddrA = 5'd3;
        #1;
        expect_val("dis_same_cycle", 0, 32'h1);
        present();
        @(negedge Clk);
        idle();
        #1;
        expect_val("dis_wr3", 0, 32'h1);
        present();

        // Scoreboard set on 9, and a set on entry 0 that must be ignored
        bus.SbSetEn = 1'b1; bus.SbSetAddr = 5'd9;
        @(negedge Clk);
        bus.SbSetAddr = 5'd0;
        bus.RdAddrA = 5'd9; bus.RdAddrB = 5'd0;
        #1;
        expect_val("sb_set9_vec", 4, 32'h0000_0200);
        expect_val("sb_set9_busyA", 2, 32'h1);
        present();
        @(negedge Clk);
        idle();
        #1;
        expect_val("sb_set0_vec", 4, 32'h0000_0200);
        expect_val("sb_set0_busyB", 3, 32'h0);
        present();

        // Retiring write to 9 clears the busy bit
        bus.RegWrEn = 1'b1; bus.WrAddr = 5'd9; bus.WriteData = 32'h99;
        #1;
        expect_val("sb_clr_same_busyA", 2, BYP ? 32'h0 : 32'h1);
        expect_val("sb_clr_same_rdA", 0, BYP ? 32'h99 : 32'h1);
        present();
        @(negedge Clk);
        idle();
        #1;
        expect_val("sb_clr_vec", 4, 32'h0);
        expect_val("sb_clr_busyA", 2, 32'h0);
        expect_val("sb_clr_rdA", 0, 32'h99);
        present();

        // Set then set+write in one cycle: set wins
        bus.SbSetEn = 1'b1; bus.SbSetAddr = 5'd9;
        @(negedge Clk);
        bus.RegWrEn = 1'b1; bus.WrAddr = 5'd9; bus.WriteData = 32'h77;
        #1;
        expect_val("sb_both_same_busyA", 2, 32'h1);
        present();
        @(negedge Clk);
        idle();
        #1;
        expect_val("sb_both_vec", 4, 32'h0000_0200);
        expect_val("sb_both_rdA", 0, 32'h77);
        present();

        // Same-cycle read of an entry being written
        bus.RegWrEn = 1'b1; bus.WrAddr = 5'd4; bus.WriteData = 32'hA5A5;
        bus.RdAddrA = 5'd4; bus.RdAddrB = 5'd4;
        #1;
        expect_val("byp_same_rdA", 0, BYP ? 32'hA5A5 : 32'h1);
        expect_val("byp_same_rdB", 1, BYP ? 32'hA5A5 : 32'h1);
        present();
        @(negedge Clk);
        idle();
        #1;
        expect_val("byp_next_rdA", 0, 32'hA5A5);
        present();

        // Small instance: top address 7, set+write together, write to 0 dropped
        bus_s.Enable = 1'b1; bus_s.RegWrEn = 1'b1; bus_s.WrAddr = 3'd7;
        bus_s.WriteData = 16'hBEEF; bus_s.SbSetEn = 1'b1; bus_s.SbSetAddr = 3'd7;
        bus_s.RdAddrA = 3'd7; bus_s.RdAddrB = 3'd6;
        @(negedge Clk);
        bus_s.SbSetEn = 1'b0; bus_s.WrAddr = 3'd0; bus_s.WriteData = 16'h1111;
        #1;
        expect_val("small_wr7", 5, 32'h0000_BEEF);
        expect_val("small_rd6", 6, 32'h0000_00FF);
        expect_val("small_busyvec", 7, 32'h0000_0080);
        present();
        @(negedge Clk);
        bus_s.RegWrEn = 1'b0;
        bus_s.RdAddrB = 3'd0;
        #1;
        expect_val("small_wr0", 6, 32'h0);
        present();

        // Reset mid-cycle overrides a pending write and set
        bus.RegWrEn = 1'b1; bus.WrAddr = 5'd7; bus.WriteData = 32'h5555;
        bus.SbSetEn = 1'b1; bus.SbSetAddr = 5'd7; bus.RdAddrA = 5'd7;
        #2 Reset_ = 1'b0;
        #1;
        expect_val("rst_mid_rd7", 0, 32'h1);
        expect_val("rst_mid_vec", 4, 32'h0);
        expect_val("rst_mid_small_rd7", 5, 32'h00FF);
        present();
        @(negedge Clk);
        #1;
        expect_val("rst_hold_rd7", 0, 32'h1);
        expect_val("rst_hold_busyA", 2, 32'h0);
        present();
        idle();
        Reset_ = 1'b1;
        @(negedge Clk);
        #1;
        expect_val("rst_after_rd7", 0, 32'h1);
        present();

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-entry register file for the 5-stage MIPS pipeline. It generalises the single enable-gated write register into NUM_REGS entries with two read ports, one write port, a hardwired-zero entry 0 and a per-entry busy scoreboard. Decode uses it to read operands and detect pending writes. Writeback uses it to retire results.

## Interface
Parameters:
- DATA_W, 32, entry width in bits.
- NUM_REGS, 32, entry count (power of two, ≥2).
- ADDR_W, $clog2(NUM_REGS), address width.
- RESET_VAL, 32'h0000_0001, reset value of entries 1..NUM_REGS-1, truncated to DATA_W.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset_  in  1  asynchronous, active-low reset.
- Enable  in  1  global enable; gates write and scoreboard updates.
- RegWrEn  in  1  write request.
- WrAddr  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- RdAddrA, RdAddrB  in  ADDR_W  read addresses.
- RdDataA, RdDataB  out  DATA_W  read data.
- RdBusyA, RdBusyB  out  1  the addressed entry has a pending write.
- SbSetEn  in  1  mark an entry busy (producer issued).
- SbSetAddr  in  ADDR_W  entry to mark.
- BusyVec  out  NUM_REGS  all busy bits; bit 0 is always 0.

## Operation
- Storage: entries 1..NUM_REGS-1 are flops. Entry 0 has no storage and reads 0.
- Write: on a rising edge with Enable & RegWrEn & (WrAddr≠0), the entry at WrAddr takes WriteData. Writes to entry 0 are discarded.
- Read: combinational. RdDataX = entry[RdAddrX], or 0 when RdAddrX=0.
- Scoreboard, per entry i≠0, on each rising edge with Enable=1:
  - the set condition is SbSetEn & SbSetAddr==i;
  - the clear condition is RegWrEn & WrAddr==i;
  - set and clear together: set wins, and the bit stays 1 because a new producer has been issued;
  - only clear: bit goes to 0;
  - only set: bit goes to 1;
  - neither: bit holds.
- Busy bit 0 is constantly 0. Setting entry 0 has no effect.
- RdBusyX = BusyVec[RdAddrX].
- Enable=0: no storage or scoreboard change. Reads remain live.

## Timing
- Reset (Reset_=0, asynchronous): entries 1..N-1 are set to RESET_VAL and all busy bits to 0. Outputs follow combinationally: RdData reads RESET_VAL, or 0 for address 0. RdBusy=0 and BusyVec=0.
- Reset asserted mid-operation overrides any same-cycle write or set. The first update after deassertion is at the next rising edge.
- Write latency: without bypass, new data is visible on the read ports 1 cycle after the write edge.
- A busy bit set at edge t is visible from t onward. A clear at edge t makes RdBusy 0 from t onward.
- Same-cycle write and read of the same address is governed by REGFILE_BYPASS_EN.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address equals WrAddr, while Enable & RegWrEn & WrAddr≠0, returns WriteData combinationally in the same cycle.
  - In the same case, RdBusy for that port reads 0 unless SbSetEn targets the same address.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value, so the write is visible next cycle.
  - RdBusy reflects the registered busy bit only.

## Structure
- Shared package rf_pkg holds:
  - DATA_W and NUM_REGS defaults;
  - the RESET_VAL default;
  - the ZERO_REG constant (0);
  - the typedef rf_addr_t.
- One sub-module, rf_read_port: address decode, zero-register masking and the optional bypass mux. It is instantiated twice, for ports A and B.
- Storage and scoreboard update live in the top module.

## Test plan
- Reset: assert Reset_=0 mid-cycle, then read addresses 0, 5 and 31 -> RdData = 0, 1, 1; BusyVec = 0 immediately, without waiting for a clock edge.
- Write 32'hDEAD_BEEF to entry 7, then read A=7 next cycle -> RdDataA = DEADBEEF. Write 32'h1234 to entry 0 -> RdData for address 0 stays 0.
- Enable=0 with RegWrEn=1 writing 32'hFFFF to entry 3 -> entry 3 still reads 1.
- Scoreboard:
  - SbSetEn on entry 9 -> BusyVec[9]=1 and RdBusyA=1 for A=9;
  - write to entry 9 -> busy bit clears after the edge;
  - set and write to entry 9 in the same cycle -> bit remains 1.
- Bypass:
  - read A=4 in the same cycle as writing 32'hA5A5 to entry 4;
  - with REGFILE_BYPASS_EN: RdDataA = A5A5 that cycle;
  - without it: the old value that cycle, A5A5 the next cycle.
- Parameter sweep: NUM_REGS=8, DATA_W=16, RESET_VAL=16'h00FF -> reset reads 00FF on entries 1..7. Writes at address 7 wrap correctly with ADDR_W=3.
